// File: rtl/mips_harvard_mem_harness.sv
// mips_harvard_mem_harness: memory and run-control harness around mips_cpu_harvard.
// The bench loads an instruction ROM and a data RAM while the CPU is held in reset.
// It then runs the CPU until it halts or times out, and logs every data write into a FIFO.
// Ports:
//   clk, reset                      - single clock, synchronous active-high reset
//   load_valid/space/addr/data      - word loader, honoured only in IDLE
//   start                           - IDLE->RUN, DONE/TIMEOUT->IDLE
//   cpu_reset, cpu_clk_enable       - CPU control (registered)
//   cpu_active                      - CPU activity, used for halt detection
//   instr_address/instr_readdata    - CPU instruction port (zero-latency read)
//   data_* ports                    - CPU data port (zero-latency read, write on edge)
//   running, done, timed_out        - registered state flags
//   cycle_count                     - RUN cycles elapsed
//   log_valid/ready/addr/data       - write-log FIFO read side
//   log_overflow, proto_error       - sticky error flags, cleared by start from IDLE
module mips_harvard_mem_harness #(
  parameter int unsigned INSTR_DEPTH    = 256,
  parameter int unsigned DATA_DEPTH     = 256,
  parameter int unsigned LOG_DEPTH      = 16,
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] DATA_BASE      = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic        load_space,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        start,
  output logic        cpu_reset,
  output logic        cpu_clk_enable,
  input  logic        cpu_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        running,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] cycle_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        proto_error
);

  localparam int unsigned IAW = $clog2(INSTR_DEPTH);
  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned LAW = $clog2(LOG_DEPTH);
  localparam int unsigned LCW = LAW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_cpu_reset, r_cpu_clk_en, r_running, r_done, r_timed_out;
  logic [31:0] r_cycle_count;
  logic        r_seen_active, r_proto_error, r_log_overflow, r_log_valid;

  logic [31:0] r_imem [INSTR_DEPTH];
  logic [31:0] r_dmem [DATA_DEPTH];
  logic [31:0] r_log_amem [LOG_DEPTH];
  logic [31:0] r_log_dmem [LOG_DEPTH];
  logic [LAW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LCW-1:0] r_log_count;

  // Address decode: word offsets from each memory's base, modular 32-bit.
  logic [29:0] w_iword, w_dword;
  logic        w_i_in_range, w_d_in_range, w_i_misaligned, w_d_misaligned;
  assign w_iword        = 30'((instr_address - RESET_VECTOR) >> 2);
  assign w_dword        = 30'((data_address - DATA_BASE) >> 2);
  assign w_i_in_range   = (w_iword < 30'(INSTR_DEPTH));
  assign w_d_in_range   = (w_dword < 30'(DATA_DEPTH));
  assign w_i_misaligned = (instr_address[1:0] != 2'b00);
  assign w_d_misaligned = (data_address[1:0] != 2'b00);

  logic w_in_idle, w_in_run, w_start_run, w_load_i, w_load_d, w_dwr_ok, w_proto;
  assign w_in_idle   = (r_state == S_IDLE);
  assign w_in_run    = (r_state == S_RUN);
  assign w_start_run = w_in_idle && start;
  assign w_load_i    = w_in_idle && load_valid && !load_space && (load_addr < 32'(INSTR_DEPTH));
  assign w_load_d    = w_in_idle && load_valid && load_space && (load_addr < 32'(DATA_DEPTH));
  assign w_dwr_ok    = w_in_run && data_write && w_d_in_range && !w_d_misaligned;
  assign w_proto     = w_i_misaligned
                     || (data_write && (!w_d_in_range || w_d_misaligned))
                     || (data_write && data_read);

  // Next-state: halt takes priority over timeout when both occur together.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        if (r_seen_active && !cpu_active)                     w_next = S_DONE;
        else if (r_cycle_count == 32'(TIMEOUT_CYCLES - 1))    w_next = S_TIMEOUT;
      end
      default: if (start) w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Registered control/flag outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_reset  <= 1'b1;
      r_cpu_clk_en <= 1'b0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_timed_out  <= 1'b0;
    end else begin
      r_cpu_reset  <= (w_next == S_IDLE);
      r_cpu_clk_en <= (w_next == S_RUN);
      r_running    <= (w_next == S_RUN);
      r_done       <= (w_next == S_DONE);
      r_timed_out  <= (w_next == S_TIMEOUT);
    end
  end

  // Cycle counter freezes on the edge that leaves RUN, so it reads TIMEOUT_CYCLES-1 on timeout.
  always_ff @(posedge clk) begin
    if (reset || w_start_run) begin
      r_cycle_count <= '0;
      r_seen_active <= 1'b0;
      r_proto_error <= 1'b0;
    end else if (w_in_run) begin
      if (w_next == S_RUN) r_cycle_count <= r_cycle_count + 32'd1;
      if (cpu_active)      r_seen_active <= 1'b1;
      if (w_proto)         r_proto_error <= 1'b1;
    end
  end

  // Memories carry no reset; loads only in IDLE, CPU writes only in RUN.
  always_ff @(posedge clk) begin
    if (w_load_i) r_imem[load_addr[IAW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (w_load_d)      r_dmem[load_addr[DAW-1:0]] <= load_data;
    else if (w_dwr_ok) r_dmem[w_dword[DAW-1:0]]   <= data_writedata;
  end

  assign instr_readdata = (w_i_in_range && !w_i_misaligned) ? r_imem[w_iword[IAW-1:0]] : 32'h0;
  assign data_readdata  = (data_read && w_d_in_range) ? r_dmem[w_dword[DAW-1:0]] : 32'h0;

  // Write log FIFO: a pop frees the slot for a same-cycle push even when full.
  logic           w_pop, w_full, w_push_ok;
  logic [LCW-1:0] w_count_next;
  assign w_pop        = r_log_valid && log_ready;
  assign w_full       = (r_log_count == LCW'(LOG_DEPTH));
  assign w_push_ok    = w_dwr_ok && (!w_full || w_pop);
  assign w_count_next = r_log_count + LCW'(w_push_ok) - LCW'(w_pop);

  always_ff @(posedge clk) begin
    if (reset || w_start_run) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_log_count    <= '0;
      r_log_valid    <= 1'b0;
      r_log_overflow <= 1'b0;
    end else begin
      if (w_push_ok)              r_wr_ptr <= r_wr_ptr + LAW'(1);
      if (w_pop)                  r_rd_ptr <= r_rd_ptr + LAW'(1);
      if (w_dwr_ok && !w_push_ok) r_log_overflow <= 1'b1;
      r_log_count <= w_count_next;
      r_log_valid <= (w_count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_log_amem[r_wr_ptr] <= data_address;
      r_log_dmem[r_wr_ptr] <= data_writedata;
    end
  end

  assign cpu_reset      = r_cpu_reset;
  assign cpu_clk_enable = r_cpu_clk_en;
  assign running        = r_running;
  assign done           = r_done;
  assign timed_out      = r_timed_out;
  assign cycle_count    = r_cycle_count;
  assign log_valid      = r_log_valid;
  assign log_addr       = r_log_amem[r_rd_ptr];
  assign log_data       = r_log_dmem[r_rd_ptr];
  assign log_overflow   = r_log_overflow;
  assign proto_error    = r_proto_error;

endmodule

// File: tb/tb_mips_harvard_mem_harness.sv
// Bench for mips_harvard_mem_harness: plays the CPU side by hand and scoreboards the write log.
`timescale 1ns/1ps
module tb_mips_harvard_mem_harness;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam int unsigned DD = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0, load_space = 1'b0, start = 1'b0;
  logic [31:0] load_addr = '0, load_data = '0;
  logic        cpu_reset, cpu_clk_enable, cpu_active = 1'b0;
  logic [31:0] instr_address = RV, instr_readdata;
  logic [31:0] data_address = '0, data_writedata = '0, data_readdata;
  logic        data_write = 1'b0, data_read = 1'b0;
  logic        running, done, timed_out;
  logic [31:0] cycle_count;
  logic        log_valid, log_ready = 1'b0;
  logic [31:0] log_addr, log_data;
  logic        log_overflow, proto_error;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t sb[$];

  mips_harvard_mem_harness #(
    .INSTR_DEPTH(256), .DATA_DEPTH(DD), .LOG_DEPTH(4),
    .RESET_VECTOR(RV), .DATA_BASE(32'h0), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_space(load_space), .load_addr(load_addr), .load_data(load_data),
    .start(start), .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable), .cpu_active(cpu_active),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .running(running), .done(done), .timed_out(timed_out), .cycle_count(cycle_count),
    .log_valid(log_valid), .log_ready(log_ready), .log_addr(log_addr), .log_data(log_data),
    .log_overflow(log_overflow), .proto_error(proto_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic sp, input logic [31:0] a, input logic [31:0] d);
    load_valid = 1'b1; load_space = sp; load_addr = a; load_data = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input bit expect_log);
    data_write = 1'b1; data_address = a; data_writedata = d;
    if (expect_log) sb.push_back('{a, d});
    tick();
    data_write = 1'b0;
  endtask

  // Scoreboard consumer: pop every visible log entry and match it with the expected queue.
  task automatic sb_drain(input int max_cycles);
    ent_t e;
    for (int i = 0; i < max_cycles && log_valid === 1'b1; i++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL log_extra: got addr=%h data=%h, required no entry", log_addr, log_data);
      end else begin
        e = sb.pop_front();
        if (log_addr !== e.a || log_data !== e.d) begin
          errors++;
          $display("FAIL log_entry: got addr=%h data=%h, required addr=%h data=%h", log_addr, log_data, e.a, e.d);
        end
      end
      log_ready = 1'b1;
      tick();
      log_ready = 1'b0;
    end
    checks++;
    if (sb.size() != 0 || log_valid !== 1'b0) begin
      errors++;
      $display("FAIL log_count: got %0d expected entries left, log_valid=%b, required 0 and 0", sb.size(), log_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    checks++; if (cpu_clk_enable !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b want 0", cpu_clk_enable); end
    checks++; if ({running, done, timed_out, log_valid, log_overflow, proto_error} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {running, done, timed_out, log_valid, log_overflow, proto_error}); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    reset = 1'b0;
    tick();
    checks++; if (cpu_reset !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL idle_hold: cpu_reset=%b running=%b want 1 0", cpu_reset, running); end
  endtask

  task automatic test_program();
    logic [31:0] reg12, reg3, loaded;
    load_word(1'b0, 32'd0, 32'h8C0C0000);
    load_word(1'b0, 32'd1, 32'h25830068);
    load_word(1'b0, 32'd2, 32'hAC030000);
    load_word(1'b0, 32'd3, 32'h00000008);
    load_word(1'b0, 32'd4, 32'h00000000);
    load_word(1'b1, 32'd0, 32'd4);
    pulse_start();
    checks++; if ({running, cpu_reset, cpu_clk_enable} !== 3'b101) begin errors++; $display("FAIL run_ctrl: got run/rst/en=%b want 101", {running, cpu_reset, cpu_clk_enable}); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL run_count0: got %0d want 0", cycle_count); end
    reg12 = 32'd0;
    cpu_active = 1'b1; instr_address = RV;
    #1;
    checks++; if (instr_readdata !== 32'h8C0C0000) begin errors++; $display("FAIL fetch0: got %h want 8c0c0000", instr_readdata); end
    tick();
    instr_address = RV + 32'd4; data_address = 32'd0; data_read = 1'b1;
    #1;
    checks++; if (instr_readdata !== 32'h25830068) begin errors++; $display("FAIL fetch1: got %h want 25830068", instr_readdata); end
    checks++; if (data_readdata !== 32'd4) begin errors++; $display("FAIL lw_data: got %h want 4", data_readdata); end
    loaded = data_readdata;
    // addiu sits in the lw delay slot and sees the old $12
    reg3 = reg12 + 32'd104;
    reg12 = loaded;
    tick();
    instr_address = RV + 32'd8; data_read = 1'b0;
    #1;
    checks++; if (instr_readdata !== 32'hAC030000) begin errors++; $display("FAIL fetch2: got %h want ac030000", instr_readdata); end
    cpu_store(32'd0, reg3, 1'b1);
    instr_address = RV + 32'd12; data_address = 32'd0; data_read = 1'b1; cpu_active = 1'b0;
    #1;
    checks++; if (data_readdata !== 32'd104) begin errors++; $display("FAIL readback: got %h want %h", data_readdata, 32'd104); end
    checks++; if (log_valid !== 1'b1) begin errors++; $display("FAIL log_visible: got %b want 1", log_valid); end
    tick();
    data_read = 1'b0;
    checks++; if ({done, running, cpu_clk_enable, cpu_reset} !== 4'b1000) begin errors++; $display("FAIL halt_flags: got %b want 1000", {done, running, cpu_clk_enable, cpu_reset}); end
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL halt_count: got %0d want 3", cycle_count); end
    checks++; if (reg12 !== 32'd4) begin errors++; $display("FAIL model_reg12: got %h want 4", reg12); end
    sb_drain(8);
  endtask

  task automatic test_timeout();
    int n;
    pulse_start();
    checks++; if ({running, done, cpu_reset, cpu_clk_enable} !== 4'b0010) begin errors++; $display("FAIL done_to_idle: got %b want 0010", {running, done, cpu_reset, cpu_clk_enable}); end
    pulse_start();
    cpu_active = 1'b1; instr_address = RV;
    n = 0;
    while (timed_out !== 1'b1 && n < 60) begin tick(); n++; end
    cpu_active = 1'b0;
    checks++; if (n != 50) begin errors++; $display("FAIL timeout_latency: got %0d cycles want 50", n); end
    checks++; if (cycle_count !== 32'd49) begin errors++; $display("FAIL timeout_count: got %0d want 49", cycle_count); end
    checks++; if ({timed_out, done, running, cpu_clk_enable} !== 4'b1000) begin errors++; $display("FAIL timeout_flags: got %b want 1000", {timed_out, done, running, cpu_clk_enable}); end
  endtask

  task automatic test_log_overflow();
    ent_t e;
    pulse_start(); pulse_start();
    cpu_active = 1'b1;
    for (int i = 0; i < 5; i++) cpu_store(32'h40 + 32'(4 * i), 32'h100 + 32'(i), i < 4);
    checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", log_overflow); end
    cpu_active = 1'b0;
    tick();
    data_address = 32'h50; data_read = 1'b1;
    #1;
    checks++; if (data_readdata !== 32'h104) begin errors++; $display("FAIL dropped_mem: got %h want 104", data_readdata); end
    data_read = 1'b0;
    sb_drain(8);
    pulse_start();
    checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", log_overflow); end
    pulse_start();
    checks++; if (log_overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b want 0", log_overflow); end
    cpu_active = 1'b1;
    for (int i = 0; i < 4; i++) cpu_store(32'h80 + 32'(4 * i), 32'h200 + 32'(i), 1'b1);
    log_ready = 1'b1; data_write = 1'b1; data_address = 32'h90; data_writedata = 32'h204;
    sb.push_back('{32'h90, 32'h204});
    #1;
    e = sb.pop_front();
    checks++; if (log_addr !== e.a || log_data !== e.d) begin errors++; $display("FAIL full_pop: got %h/%h want %h/%h", log_addr, log_data, e.a, e.d); end
    tick();
    log_ready = 1'b0; data_write = 1'b0;
    checks++; if (log_overflow !== 1'b0) begin errors++; $display("FAIL push_pop_full: overflow=%b want 0", log_overflow); end
    cpu_active = 1'b0;
    tick();
    sb_drain(8);
  endtask

  task automatic test_proto_error();
    pulse_start(); pulse_start();
    checks++; if (proto_error !== 1'b0 || log_valid !== 1'b0) begin errors++; $display("FAIL proto_start: proto=%b log_valid=%b want 0 0", proto_error, log_valid); end
    cpu_active = 1'b1;
    cpu_store(DD * 4, 32'hDEADBEEF, 1'b0);
    checks++; if (proto_error !== 1'b1) begin errors++; $display("FAIL proto_oob_write: got %b want 1", proto_error); end
    checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL oob_no_log: got %b want 0", log_valid); end
    data_read = 1'b1; data_address = 32'd0;
    #1;
    checks++; if (data_readdata !== 32'd104) begin errors++; $display("FAIL oob_no_alias: got %h want %h", data_readdata, 32'd104); end
    data_address = DD * 4;
    #1;
    checks++; if (data_readdata !== 32'd0) begin errors++; $display("FAIL oob_read: got %h want 0", data_readdata); end
    data_address = 32'd0; data_write = 1'b1; data_writedata = 32'h5A5A5A5A;
    sb.push_back('{32'd0, 32'h5A5A5A5A});
    #1;
    checks++; if (data_readdata !== 32'd104) begin errors++; $display("FAIL rw_old_data: got %h want %h", data_readdata, 32'd104); end
    tick();
    data_write = 1'b0;
    #1;
    checks++; if (data_readdata !== 32'h5A5A5A5A || log_valid !== 1'b1) begin errors++; $display("FAIL rw_new_data: got %h log_valid=%b want 5a5a5a5a 1", data_readdata, log_valid); end
    data_read = 1'b0; cpu_active = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL proto_halt: got %b want 1", done); end
  endtask

  task automatic test_restart();
    checks++; if (log_valid !== 1'b1) begin errors++; $display("FAIL done_log_readable: got %b want 1", log_valid); end
    pulse_start();
    checks++; if ({done, cpu_reset, proto_error} !== 3'b011) begin errors++; $display("FAIL restart_idle: got %b want 011", {done, cpu_reset, proto_error}); end
    load_word(1'b0, 32'd0, 32'h24020007);
    sb.delete();
    pulse_start();
    checks++; if ({running, log_valid, log_overflow, proto_error} !== 4'b1000) begin errors++; $display("FAIL restart_clear: got %b want 1000", {running, log_valid, log_overflow, proto_error}); end
    instr_address = RV;
    #1;
    checks++; if (instr_readdata !== 32'h24020007) begin errors++; $display("FAIL reload: got %h want 24020007", instr_readdata); end
    cpu_active = 1'b1; instr_address = RV + 32'd2;
    #1;
    checks++; if (instr_readdata !== 32'd0) begin errors++; $display("FAIL misaligned_fetch: got %h want 0", instr_readdata); end
    tick();
    checks++; if (proto_error !== 1'b1) begin errors++; $display("FAIL proto_misaligned: got %b want 1", proto_error); end
    instr_address = RV + 32'd1024;
    #1;
    checks++; if (instr_readdata !== 32'd0) begin errors++; $display("FAIL fetch_oob: got %h want 0", instr_readdata); end
    instr_address = RV; cpu_active = 1'b0;
    tick();
  endtask

  task automatic test_run_ignore_and_reset();
    pulse_start();
    load_word(1'b0, 32'd5, 32'hCAFEF00D);
    pulse_start();
    load_valid = 1'b1; load_space = 1'b0; load_addr = 32'd5; load_data = 32'h12345678;
    tick();
    load_valid = 1'b0; instr_address = RV + 32'd20;
    #1;
    checks++; if (instr_readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL run_load_ignored: got %h want cafef00d", instr_readdata); end
    tick(); tick();
    checks++; if (cycle_count !== 32'd3 || running !== 1'b1) begin errors++; $display("FAIL run_cycle3: count=%0d running=%b want 3 1", cycle_count, running); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({cpu_reset, running, cpu_clk_enable} !== 3'b100 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL midrun_reset: rst/run/en=%b count=%0d want 100 0", {cpu_reset, running, cpu_clk_enable}, cycle_count); end
    instr_address = RV;
    tick();
    checks++; if (cpu_reset !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL post_reset_idle: rst=%b run=%b want 1 0", cpu_reset, running); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_timeout();
    test_log_overflow();
    test_proto_error();
    test_restart();
    test_run_ignore_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
